// File: rtl/oser_pkg.sv
// Shared types and constants for the OSER8 feeder: controller states,
// serializer ratios and the word record carried through the input buffer.
package oser_pkg;

    localparam int OSER8_RATIO = 8;
    localparam int PCLK_DIV    = 4;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic [OSER8_RATIO-1:0] data;
        logic [3:0]             tx;
    } oser_word_t;

endpackage

// File: rtl/oser_word_fifo.sv
// Synchronous word FIFO with registered pointers; no write-to-read bypass,
// so a word pushed into an empty FIFO is poppable from the following clk.
module oser_word_fifo
    import oser_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic [11:0] wdata_i,
    input  logic        pop_i,
    output logic [11:0] rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    oser_word_t  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= oser_word_t'(wdata_i);
    end

endmodule

// File: rtl/oser8_feeder.sv
// OSER8 sequencing controller: derives PCLK = FCLK/4, holds the serializer
// in reset after power-up, then feeds one buffered word per PCLK period.
module oser8_feeder
    import oser_pkg::*;
#(
    parameter int         RST_CYCLES  = 16,
    parameter int         ALIGN_WORDS = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] IDLE_WORD   = 8'h00,
    parameter logic [3:0] IDLE_TX     = 4'hF
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  in_data,
    input  logic [3:0]  in_tx,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        oser_reset,
    output logic        pclk,
    output logic [7:0]  d,
    output logic [3:0]  tx,
    output logic        running,
    output logic        underflow,
    output logic [15:0] underflow_cnt,
    output logic [1:0]  state_o
);

    // Handshake: a word transfers on every rising clk where in_valid and
    // in_ready are both high; in_ready never depends on in_valid.

    localparam int         PW         = $clog2(PCLK_DIV);
    localparam logic [7:0] RST_LIMIT  = 8'(RST_CYCLES);
    localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_WORDS - 1);
    localparam oser_word_t IDLE_W     = '{data: IDLE_WORD, tx: IDLE_TX};

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [3:0]    align_cnt_q, align_cnt_d;
    logic          oser_reset_q, oser_reset_d;
    oser_word_t    word_q, word_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   ucnt_q, ucnt_d;
    logic          ready_en_q;
    logic          boundary, fifo_full, fifo_empty, push, pop;
    logic [11:0]   head_bits;

    // A word boundary is the edge on which the phase wraps back to zero.
    assign boundary = (phase_q == PW'(PCLK_DIV - 1));
    assign in_ready = ready_en_q && !fifo_full;
    assign push     = in_valid && in_ready;

    oser_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i ({in_data, in_tx}),
        .pop_i   (pop),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        align_cnt_d  = align_cnt_q;
        oser_reset_d = oser_reset_q;
        word_d       = word_q;
        underflow_d  = 1'b0;
        ucnt_d       = ucnt_q;
        pop          = 1'b0;
        case (state_q)
            HOLD: begin
                oser_reset_d = 1'b1;
                if (hold_cnt_q != RST_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else if (boundary) begin
                    state_d      = ALIGN;
                    oser_reset_d = 1'b0;
                    align_cnt_d  = '0;
                end
            end
            ALIGN: begin
                word_d = IDLE_W;
                if (boundary) begin
                    if (align_cnt_q == ALIGN_LAST) state_d = RUN;
                    else                           align_cnt_d = align_cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (boundary) begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        word_d = oser_word_t'(head_bits);
                    end else begin
                        word_d      = IDLE_W;
                        underflow_d = 1'b1;
                        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                    end
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= HOLD;
            phase_q      <= '0;
            hold_cnt_q   <= '0;
            align_cnt_q  <= '0;
            oser_reset_q <= 1'b1;
            word_q       <= IDLE_W;
            underflow_q  <= 1'b0;
            ucnt_q       <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_q + 1'b1;
            hold_cnt_q   <= hold_cnt_d;
            align_cnt_q  <= align_cnt_d;
            oser_reset_q <= oser_reset_d;
            word_q       <= word_d;
            underflow_q  <= underflow_d;
            ucnt_q       <= ucnt_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign oser_reset    = oser_reset_q;
    assign pclk          = phase_q[PW-1];
    assign d             = word_q.data;
    assign tx            = word_q.tx;
    assign running       = (state_q == RUN);
    assign underflow     = underflow_q;
    assign underflow_cnt = ucnt_q;
    assign state_o       = state_q;

endmodule
